// File: rtl/perf_pkg.sv
// Shared types and constants for the performance-monitor slice.
package perf_pkg;

    localparam int PERF_CNT_W = 32;

    // Indices into the live/snapshot counter banks.
    localparam int NUM_CNT   = 5;
    localparam int CNT_CYC   = 0;
    localparam int CNT_XFER  = 1;
    localparam int CNT_RD    = 2;
    localparam int CNT_WAIT  = 3;
    localparam int CNT_ABORT = 4;

    typedef enum logic [2:0] {
        SEL_CYC     = 3'd0,
        SEL_XFER    = 3'd1,
        SEL_RD      = 3'd2,
        SEL_WAIT    = 3'd3,
        SEL_MAX_LAT = 3'd4,
        SEL_ABORT   = 3'd5
    } perf_sel_t;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } lat_state_t;

endpackage

// File: rtl/wishbone.sv
// Minimal Wishbone handshake bundle; the monitor modport is read-only.
interface wishbone;
    logic cyc;
    logic stb;
    logic we;
    logic ack;

    modport master  (output cyc, stb, we, input ack);
    modport slave   (input cyc, stb, we, output ack);
    modport monitor (input cyc, stb, we, ack);
endinterface

// File: rtl/perf_sat_cnt.sv
// Saturating event counter with synchronous clear; clear beats increment.
module perf_sat_cnt #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] q
);

    always_ff @(posedge clk) begin
        if (rst || clr)
            q <= '0;
        else if (inc && (q != {W{1'b1}}))
            q <= q + W'(1);
    end

endmodule

// File: rtl/wb_perf_monitor.sv
// Passive per-master Wishbone event counter with snapshot bank and
// registered readout.
module wb_perf_monitor
    import perf_pkg::*;
#(
    parameter int CNT_W = PERF_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    wishbone.monitor         m,
    input  logic             en,
    input  logic             clr,
    input  logic             snap,
    input  logic [2:0]       sel,
    output logic [CNT_W-1:0] dout
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic ev_busy, ev_wait, ev_xfer, ev_read, ev_abort;
    logic done;
    logic [CNT_W-1:0] lat, lat_inc, done_lat, max_lat, shot_max, dout_nxt;
    logic [NUM_CNT-1:0] inc;
    logic [NUM_CNT-1:0][CNT_W-1:0] live, shot;
    lat_state_t state, state_nxt;

    assign ev_busy = m.cyc;
    assign ev_wait = m.cyc & m.stb & ~m.ack;
    assign ev_xfer = m.cyc & m.stb & m.ack;
    assign ev_read = ev_xfer & ~m.we;
    assign lat_inc = (lat == CNT_MAX) ? lat : lat + CNT_W'(1);

    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (ev_wait) state_nxt = WAIT;
            WAIT:    if (ev_xfer || !m.cyc) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        done     = 1'b0;
        ev_abort = 1'b0;
        done_lat = CNT_W'(1);
        case (state)
            IDLE: done = ev_xfer;
            WAIT: begin
                done     = ev_xfer;
                done_lat = lat_inc;
                ev_abort = ~m.cyc;
            end
            default: ;
        endcase
    end

    // Latency tracking ignores en so a transfer straddling an en edge is measured fully.
    always_ff @(posedge clk) begin
        if (rst)
            lat <= '0;
        else if (ev_wait && state == IDLE)
            lat <= CNT_W'(1);
        else if (ev_wait && state == WAIT)
            lat <= lat_inc;
    end

    assign inc = en ? {ev_abort, ev_wait, ev_read, ev_xfer, ev_busy} : '0;

    for (genvar i = 0; i < NUM_CNT; i++) begin : g_cnt
        perf_sat_cnt #(.W(CNT_W)) u_cnt (
            .clk (clk),
            .rst (rst),
            .clr (clr),
            .inc (inc[i]),
            .q   (live[i])
        );
    end

    always_ff @(posedge clk) begin
        if (rst || clr)
            max_lat <= '0;
        else if (en && done && (done_lat > max_lat))
            max_lat <= done_lat;
    end

    // Snapshot samples pre-edge values, so snap+clr is an atomic read-and-clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            shot     <= '0;
            shot_max <= '0;
        end else if (snap) begin
            shot     <= live;
            shot_max <= max_lat;
        end
    end

    always_comb begin
        dout_nxt = '0;
        case (perf_sel_t'(sel))
            SEL_CYC:     dout_nxt = shot[CNT_CYC];
            SEL_XFER:    dout_nxt = shot[CNT_XFER];
            SEL_RD:      dout_nxt = shot[CNT_RD];
            SEL_WAIT:    dout_nxt = shot[CNT_WAIT];
            SEL_MAX_LAT: dout_nxt = shot_max;
            SEL_ABORT:   dout_nxt = shot[CNT_ABORT];
            default:     dout_nxt = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst)
            dout <= '0;
        else
            dout <= dout_nxt;
    end

endmodule

// File: tb/tb_wb_perf_monitor.sv
// Bench for wb_perf_monitor: a 32-bit instance for function, a 4-bit one for saturation.
module tb_wb_perf_monitor;

    logic        clk = 1'b0;
    logic        rst;
    logic        en, clr, snap;
    logic [2:0]  sel;
    logic [31:0] dout32;
    logic [3:0]  dout4;

    wishbone wb0 ();
    wishbone wb1 ();

    wb_perf_monitor #(.CNT_W(32)) dut32 (
        .clk(clk), .rst(rst), .m(wb0), .en(en), .clr(clr),
        .snap(snap), .sel(sel), .dout(dout32)
    );

    wb_perf_monitor #(.CNT_W(4)) dut4 (
        .clk(clk), .rst(rst), .m(wb1), .en(en), .clr(clr),
        .snap(snap), .sel(sel), .dout(dout4)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        string       name;
        bit          which;
        logic [31:0] exp;
    } sb_t;
    sb_t sbq[$];

    // One bus scenario and the counter values its snapshot must hold.
    typedef struct {
        int          nw;
        logic        we;
        logic        abort;
        int          reps;
        logic [31:0] e_cyc, e_xfer, e_rd, e_wait, e_max, e_abort;
    } rec_t;
    rec_t recs[5];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic bus(input bit which, input logic c, input logic s, input logic w, input logic a);
        if (which) begin
            wb1.cyc = c; wb1.stb = s; wb1.we = w; wb1.ack = a;
        end else begin
            wb0.cyc = c; wb0.stb = s; wb0.we = w; wb0.ack = a;
        end
        step();
    endtask

    // Drive sel, queue the expectation, pop and compare once dout is due.
    task automatic rd(input bit which, input logic [2:0] s, input logic [31:0] e, input string name);
        sb_t t;
        sel = s;
        sbq.push_back('{name, which, e});
        step();
        t = sbq.pop_front();
        check(t.name, t.which ? {28'd0, dout4} : dout32, t.exp);
    endtask

    task automatic read_all(input bit which, input string tag,
                            input logic [31:0] c, input logic [31:0] x, input logic [31:0] r,
                            input logic [31:0] w, input logic [31:0] mx, input logic [31:0] ab);
        rd(which, 3'd0, c,  {tag, ".cyc"});
        rd(which, 3'd1, x,  {tag, ".xfer"});
        rd(which, 3'd2, r,  {tag, ".rd"});
        rd(which, 3'd3, w,  {tag, ".wait"});
        rd(which, 3'd4, mx, {tag, ".max_lat"});
        rd(which, 3'd5, ab, {tag, ".abort"});
        rd(which, 3'd6, 0,  {tag, ".sel6"});
        rd(which, 3'd7, 0,  {tag, ".sel7"});
    endtask

    task automatic do_snap(input logic with_clr);
        snap = 1'b1;
        clr  = with_clr;
        step();
        snap = 1'b0;
        clr  = 1'b0;
    endtask

    task automatic run_rec(input rec_t r);
        for (int t = 0; t < r.reps; t++) begin
            for (int k = 0; k < r.nw; k++) bus(0, 1, 1, r.we, 0);
            if (r.abort) bus(0, 0, 0, r.we, 0);
            else         bus(0, 1, 1, r.we, 1);
        end
        bus(0, 0, 0, 0, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        recs[0] = '{3, 1'b0, 1'b0, 1, 4,  1, 1, 3,  4, 0};
        recs[1] = '{0, 1'b1, 1'b0, 8, 8,  8, 0, 0,  1, 0};
        recs[2] = '{2, 1'b0, 1'b1, 1, 2,  0, 0, 2,  0, 1};
        recs[3] = '{1, 1'b0, 1'b0, 3, 6,  3, 3, 3,  2, 0};
        recs[4] = '{5, 1'b1, 1'b0, 2, 12, 2, 0, 10, 6, 0};

        rst = 1'b1; en = 1'b1; clr = 1'b0; snap = 1'b0; sel = 3'd0;
        wb0.cyc = 0; wb0.stb = 0; wb0.we = 0; wb0.ack = 0;
        wb1.cyc = 0; wb1.stb = 0; wb1.we = 0; wb1.ack = 0;
        repeat (3) step();
        rst = 1'b0;
        check("reset.dout32", dout32, 0);
        check("reset.dout4", {28'd0, dout4}, 0);

        repeat (20) bus(0, 0, 0, 0, 0);
        do_snap(1'b0);
        read_all(0, "idle32", 0, 0, 0, 0, 0, 0);
        read_all(1, "idle4", 0, 0, 0, 0, 0, 0);

        for (int i = 0; i < 5; i++) begin
            run_rec(recs[i]);
            do_snap(1'b1);
            read_all(0, $sformatf("rec%0d", i), recs[i].e_cyc, recs[i].e_xfer,
                     recs[i].e_rd, recs[i].e_wait, recs[i].e_max, recs[i].e_abort);
        end

        // dout follows sel one edge later (snapshot still holds rec4).
        sel = 3'd3;
        step();
        check("lat.sel3", dout32, 10);
        sel = 3'd4;
        #2;
        check("lat.before_edge", dout32, 10);
        step();
        check("lat.after_edge", dout32, 6);

        // Abort leaves xfer/max_lat alone; later 2-cycle transfer sets max_lat.
        bus(0, 1, 1, 0, 0);
        bus(0, 1, 1, 0, 0);
        bus(0, 0, 0, 0, 0);
        bus(0, 1, 1, 0, 0);
        bus(0, 1, 1, 0, 1);
        bus(0, 0, 0, 0, 0);
        do_snap(1'b1);
        read_all(0, "abort_then_xfer", 4, 1, 1, 3, 2, 1);

        // Atomic snap+clr coinciding with an ack after five transfers.
        repeat (5) bus(0, 1, 1, 1, 1);
        snap = 1'b1; clr = 1'b1;
        bus(0, 1, 1, 1, 1);
        snap = 1'b0; clr = 1'b0;
        sel = 3'd1;
        bus(0, 0, 0, 0, 0);
        check("snapclr.xfer", dout32, 5);
        snap = 1'b1;
        step();
        snap = 1'b0;
        step();
        check("snapclr.next_xfer", dout32, 0);
        sel = 3'd0;
        step();
        check("snapclr.next_cyc", dout32, 0);

        // Reset mid-transfer: stale wait states must not leak into latency.
        bus(0, 1, 1, 0, 0);
        bus(0, 1, 1, 0, 0);
        bus(0, 1, 1, 0, 0);
        rst = 1'b1;
        bus(0, 1, 1, 0, 0);
        rst = 1'b0;
        bus(0, 1, 1, 0, 1);
        bus(0, 0, 0, 0, 0);
        do_snap(1'b0);
        read_all(0, "rst_mid", 1, 1, 1, 0, 1, 0);

        // 4-bit instance: 20 busy cycles, 3 with en=0 inside a 7-cycle transfer.
        bus(1, 1, 0, 0, 0);
        bus(1, 1, 0, 0, 0);
        bus(1, 1, 1, 0, 0);
        en = 1'b0;
        repeat (3) bus(1, 1, 1, 0, 0);
        en = 1'b1;
        repeat (2) bus(1, 1, 1, 0, 0);
        bus(1, 1, 1, 0, 1);
        repeat (11) bus(1, 1, 0, 0, 0);
        bus(1, 0, 0, 0, 0);
        do_snap(1'b0);
        read_all(1, "sat4", 15, 1, 1, 3, 7, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/wb_perf_monitor.md
# wb_perf_monitor

Per-master bus event counter for the performance unit. Watches one Wishbone master through a monitor port and counts busy cycles, completed transfers, reads, wait states, aborts and worst-case transfer latency. `perf_top` instantiates one per monitored master (m0, m1), drives `snap`/`clr` from its control register and maps `sel`/`dout` into its slave register space. Counting is passive: the block never drives the bus.

## Interface
Parameters:
- `CNT_W`, 32, width of every counter and of `dout`.

Ports:
- `clk`  in  1  system clock; single clock domain.
- `rst`  in  1  reset; synchronous, active-high.
- `m`  wishbone.monitor  -  observed master; uses `cyc`, `stb`, `we`, `ack`.
- `en`  in  1  count enable; 0 freezes all live counters.
- `clr`  in  1  synchronous clear of all live counters and max latency.
- `snap`  in  1  copy all live counters into snapshot registers.
- `sel`  in  3  snapshot register select (codes below).
- `dout`  out  CNT_W  selected snapshot value, registered.

## Operation
Events are sampled each `clk` edge:
- busy = `cyc`
- wait = `cyc & stb & !ack`
- xfer = `cyc & stb & ack`
- read = xfer & !`we`

Live counters:
- `cyc_cnt` += busy.
- `xfer_cnt` += xfer.
- `rd_cnt` += read.
- `wait_cnt` += wait.
- `abort_cnt` += abort (defined below).
- `max_lat` = max(`max_lat`, completed latency).

Latency FSM (states IDLE, WAIT; internal `lat` counter, CNT_W bits):
- IDLE, wait: `lat`←1, go to WAIT.
- IDLE, xfer: completed latency 1, stay in IDLE.
- IDLE, otherwise: stay.
- WAIT, wait: `lat`←`lat`+1 (saturating).
- WAIT, xfer: completed latency `lat`+1, go to IDLE.
- WAIT, `cyc`=0: abort event; go to IDLE with no latency update.
- WAIT, `cyc`=1 and `stb`=0: hold `lat`, stay in WAIT.

Back-to-back transfers (`stb` held high across `ack`): each `ack` closes one transfer, and the next transfer starts in the following cycle from IDLE.

Arithmetic and priority rules:
- All counters saturate at 2^CNT_W−1 and never wrap.
- `clr` has priority over any increment in the same cycle; that cycle's event is lost.
- `en`=0 freezes the counters and `max_lat`. The FSM still tracks state so latency stays correct when `en` rises mid-transfer.
- `snap` captures register values as they were before the current edge's update.
- `snap` and `clr` in the same cycle gives atomic read-and-clear: snapshot gets the pre-clear values, live counters go to 0.
- Reset mid-transfer: FSM to IDLE, all live and snapshot registers to 0. The ongoing transfer is neither counted nor aborted.

`sel` codes:
- 0 `cyc_cnt`
- 1 `xfer_cnt`
- 2 `rd_cnt`
- 3 `wait_cnt`
- 4 `max_lat`
- 5 `abort_cnt`
- 6, 7 read as 0.

## Timing
- Reset values: all counters, snapshots, `lat` and `dout` are 0; FSM is IDLE.
- Event to live counter: an event at edge N is visible in the live counter after edge N.
- `snap` to snapshot: `snap` at edge N makes the snapshot valid after edge N.
- `sel` to `dout`: `sel` sampled at edge N; `dout` valid after edge N, so one cycle of latency. This fits `perf_top` registering `ack` one cycle after `stb`.
- `dout` updates every cycle from the current `sel` and snapshot contents. A `snap` at edge N is reflected in `dout` after edge N+1.
- No handshake on `snap`/`clr`: each is a single-cycle strobe, and holding one high repeats the action every cycle.

## Structure
- Package `perf_pkg` holds:
  - `perf_sel_t`, the enum of `sel` codes;
  - `lat_state_t` {IDLE, WAIT};
  - the `PERF_CNT_W` default constant.
- Sub-module `perf_sat_cnt` (inputs clk, rst, clr, inc; output q; width parameter): saturating counter used five times. `max_lat` and the snapshot bank are inline.

## Test plan
- Reset then idle bus for 20 cycles: every `sel` reads 0, including codes 6 and 7.
- Single read with 3 wait states (`stb` 4 cycles, `ack` on the 4th, `we`=0), then `snap`, `sel`=4: `max_lat`=4, `xfer_cnt`=1, `rd_cnt`=1, `wait_cnt`=3, `cyc_cnt`=4. Check `dout` arrives one cycle after `sel`.
- Burst of 8 zero-wait writes (`stb`=`ack`=1 for 8 cycles): `xfer_cnt`=8, `rd_cnt`=0, `wait_cnt`=0, `max_lat`=1.
- `cyc` dropped after 2 wait cycles with no `ack`: `abort_cnt`=1, `xfer_cnt` and `max_lat` unchanged. A later 2-cycle transfer gives `max_lat`=2.
- `snap` and `clr` asserted together with an `ack` in the same cycle, after 5 transfers: snapshot `xfer_cnt`=5; next `snap` gives 0.
- Saturation: CNT_W=4, 20 busy cycles: `cyc_cnt`=15. Toggling `en`=0 for 3 of them mid-transfer leaves `max_lat` still measured from `stb` start.
